// File: rtl/eth_rx_fcs_check.sv
// rtl/eth_rx_fcs_check.sv - GMII receive FCS/length/PHY-error checker with FCS stripping.
// Optional good/bad frame counters are built when ETH_RX_STATS_EN is defined.
module eth_rx_fcs_check #(
   parameter int MAX_FRAME_LEN = 1518,
   parameter int MIN_FRAME_LEN = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_dv,
   input  logic       rx_er,
   input  logic [7:0] rxd,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_first,
   output logic       out_last,
   output logic       stat_valid,
   output logic       stat_good,
   output logic       stat_crc_err,
   output logic       stat_len_err,
   output logic       stat_phy_err
`ifdef ETH_RX_STATS_EN
   ,
   output logic [31:0] rx_good_cnt,
   output logic [31:0] rx_bad_cnt
`endif
);

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   localparam logic [11:0] MIN_LEN     = 12'(MIN_FRAME_LEN);
   localparam logic [11:0] MAX_LEN     = 12'(MAX_FRAME_LEN);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   state_t      state, state_nxt;
   logic [31:0] crc_q;
   logic [31:0] crc_next;
   logic [11:0] len_q;
   logic        phy_q;
   logic [7:0]  hold_q [4];
   logic [7:0]  pend_q;
   logic        pend_v_q;
   logic        pend_first_q;

   logic        b_valid, b_first, b_last, b_stat;
   logic [7:0]  b_data;
   logic        b_crc_err, b_len_err, b_phy_err;

   logic        sfd_seen, data_byte, frame_end;

   // Register shifts MSB-first while the byte is fed LSB-first, matching wire bit order.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
      end
      return r;
   endfunction

   assign crc_next  = crc_byte(crc_q, rxd);
   assign sfd_seen  = (state == PREAMBLE) && rx_dv && !rx_er && (rxd == 8'hD5);
   assign data_byte = (state == DATA) && rx_dv;
   assign frame_end = (state == DATA) && !rx_dv;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rx_dv) begin
               if (!rx_er && rxd == 8'h55) state_nxt = PREAMBLE;
               else                        state_nxt = DROP;
            end
         end
         PREAMBLE: begin
            if (!rx_dv)               state_nxt = IDLE;
            else if (rx_er)           state_nxt = DROP;
            else if (rxd == 8'hD5)    state_nxt = DATA;
            else if (rxd != 8'h55)    state_nxt = DROP;
         end
         DATA: begin
            if (!rx_dv) state_nxt = IDLE;
         end
         DROP: begin
            if (!rx_dv) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The last four DATA bytes may be FCS, so a byte is released only once four more follow it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q        <= 32'hFFFFFFFF;
         len_q        <= '0;
         phy_q        <= 1'b0;
         for (int i = 0; i < 4; i++) hold_q[i] <= '0;
         pend_q       <= '0;
         pend_v_q     <= 1'b0;
         pend_first_q <= 1'b0;
         b_valid      <= 1'b0;
         b_data       <= '0;
         b_first      <= 1'b0;
         b_last       <= 1'b0;
         b_stat       <= 1'b0;
         b_crc_err    <= 1'b0;
         b_len_err    <= 1'b0;
         b_phy_err    <= 1'b0;
      end else begin
         b_valid <= 1'b0;
         b_first <= 1'b0;
         b_last  <= 1'b0;
         b_stat  <= 1'b0;
         if (sfd_seen) begin
            crc_q    <= 32'hFFFFFFFF;
            len_q    <= '0;
            phy_q    <= 1'b0;
            pend_v_q <= 1'b0;
         end
         if (data_byte) begin
            crc_q     <= crc_next;
            len_q     <= (len_q == 12'hFFF) ? len_q : len_q + 12'd1;
            if (rx_er) phy_q <= 1'b1;
            hold_q[0] <= rxd;
            hold_q[1] <= hold_q[0];
            hold_q[2] <= hold_q[1];
            hold_q[3] <= hold_q[2];
            if (len_q >= 12'd4) begin
               pend_q       <= hold_q[3];
               pend_v_q     <= 1'b1;
               pend_first_q <= (len_q == 12'd4);
            end
            if (pend_v_q) begin
               b_valid <= 1'b1;
               b_data  <= pend_q;
               b_first <= pend_first_q;
            end
         end
         if (frame_end) begin
            if (pend_v_q) begin
               b_valid <= 1'b1;
               b_data  <= pend_q;
               b_first <= pend_first_q;
               b_last  <= 1'b1;
            end
            pend_v_q  <= 1'b0;
            b_stat    <= 1'b1;
            b_crc_err <= (crc_q != CRC_RESIDUE);
            b_len_err <= (len_q < MIN_LEN) || (len_q > MAX_LEN);
            b_phy_err <= phy_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_first    <= 1'b0;
         out_last     <= 1'b0;
         stat_valid   <= 1'b0;
         stat_good    <= 1'b0;
         stat_crc_err <= 1'b0;
         stat_len_err <= 1'b0;
         stat_phy_err <= 1'b0;
      end else begin
         out_valid    <= b_valid;
         out_data     <= b_data;
         out_first    <= b_first;
         out_last     <= b_last;
         stat_valid   <= b_stat;
         stat_good    <= b_stat & ~(b_crc_err | b_len_err | b_phy_err);
         stat_crc_err <= b_stat & b_crc_err;
         stat_len_err <= b_stat & b_len_err;
         stat_phy_err <= b_stat & b_phy_err;
      end
   end

`ifdef ETH_RX_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_good_cnt <= '0;
         rx_bad_cnt  <= '0;
      end else if (stat_valid) begin
         if (stat_good) begin
            if (rx_good_cnt != 32'hFFFFFFFF) rx_good_cnt <= rx_good_cnt + 32'd1;
         end else begin
            if (rx_bad_cnt != 32'hFFFFFFFF) rx_bad_cnt <= rx_bad_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb/tb_eth_rx_fcs_check.sv - scoreboard bench for eth_rx_fcs_check.
module tb_eth_rx_fcs_check;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_dv, rx_er;
   logic [7:0] rxd;
   logic       out_valid, out_first, out_last;
   logic [7:0] out_data;
   logic       stat_valid, stat_good, stat_crc_err, stat_len_err, stat_phy_err;
`ifdef ETH_RX_STATS_EN
   logic [31:0] rx_good_cnt, rx_bad_cnt;
`endif

   eth_rx_fcs_check #(.MAX_FRAME_LEN(1518), .MIN_FRAME_LEN(64)) dut (
      .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
      .out_valid(out_valid), .out_data(out_data), .out_first(out_first), .out_last(out_last),
      .stat_valid(stat_valid), .stat_good(stat_good), .stat_crc_err(stat_crc_err),
      .stat_len_err(stat_len_err), .stat_phy_err(stat_phy_err)
`ifdef ETH_RX_STATS_EN
      , .rx_good_cnt(rx_good_cnt), .rx_bad_cnt(rx_bad_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int e; logic [7:0] d; logic f; logic l; } out_t;
   typedef struct { int e; logic g; logic c; logic n; logic p; } st_t;

   out_t       oq[$];
   st_t        sq[$];
   logic [7:0] fr[$];
   int         cyc = 0;
   int         compared = 0;
   int         mismatched = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference FCS uses the reflected table-free form; a frame including FCS leaves 0xDEBB20E3.
   function automatic logic [31:0] crc_refl(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < n; k++) begin
         c = c ^ {24'h0, fr[k]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   task automatic build(input int plen, input logic [7:0] start, input bit add_fcs, input logic [7:0] fcs3_xor);
      logic [31:0] fcs;
      fr.delete();
      for (int k = 0; k < plen; k++) fr.push_back(8'(start + 8'(k)));
      if (add_fcs) begin
         fcs = ~crc_refl(plen);
         fr.push_back(fcs[7:0]);
         fr.push_back(fcs[15:8]);
         fr.push_back(fcs[23:16]);
         fr.push_back(fcs[31:24] ^ fcs3_xor);
      end
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      @(negedge clk);
      rx_dv = dv;
      rx_er = er;
      rxd   = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int er_idx, input int rst_at);
      int   n;
      bit   aborted;
      out_t o;
      st_t  s;
      n = fr.size();
      aborted = 0;
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int k = 0; k < n; k++) begin
         if (k == rst_at) begin
            while (oq.size() > 0 && oq[$].e > cyc) void'(oq.pop_back());
            aborted = 1;
            reset = 1'b1;
         end
         if (rst_at >= 0 && k == rst_at + 3) reset = 1'b0;
         drive(1'b1, (k == er_idx), fr[k]);
         if (reset) begin
            #1;
            chk("rst_mid_out_valid", out_valid, 0);
            chk("rst_mid_stat_valid", stat_valid, 0);
         end
         if (!aborted && k < n - 4) begin
            o.e = cyc + 7;
            o.d = fr[k];
            o.f = (k == 0);
            o.l = (k == n - 5);
            oq.push_back(o);
         end
      end
      drive(1'b0, 1'b0, 8'h00);
      if (!aborted) begin
         s.e = cyc + 2;
         s.c = (crc_refl(n) != 32'hDEBB20E3);
         s.n = (n < 64) || (n > 1518);
         s.p = (er_idx >= 0) && (er_idx < n);
         s.g = !(s.c || s.n || s.p);
         sq.push_back(s);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (oq.size() > 0 && oq[0].e == cyc) begin
         chk("out_valid", out_valid, 1);
         chk("out_data", out_data, oq[0].d);
         chk("out_first", out_first, oq[0].f);
         chk("out_last", out_last, oq[0].l);
         void'(oq.pop_front());
      end else begin
         chk("out_valid_idle", out_valid, 0);
      end
      if (sq.size() > 0 && sq[0].e == cyc) begin
         chk("stat_valid", stat_valid, 1);
         chk("stat_good", stat_good, sq[0].g);
         chk("stat_crc_err", stat_crc_err, sq[0].c);
         chk("stat_len_err", stat_len_err, sq[0].n);
         chk("stat_phy_err", stat_phy_err, sq[0].p);
         void'(sq.pop_front());
      end else begin
         chk("stat_valid_idle", stat_valid, 0);
      end
   end

   initial begin
      reset = 1'b1;
      rx_dv = 1'b0;
      rx_er = 1'b0;
      rxd   = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_first", out_first, 0);
      chk("reset_out_last", out_last, 0);
      chk("reset_stat_valid", stat_valid, 0);
      chk("reset_stat_good", stat_good, 0);
      chk("reset_stat_errs", {stat_crc_err, stat_len_err, stat_phy_err}, 0);
`ifdef ETH_RX_STATS_EN
      chk("reset_good_cnt", rx_good_cnt, 0);
      chk("reset_bad_cnt", rx_bad_cnt, 0);
`endif
      reset = 1'b0;
      idle(4);

      build(60, 8'h00, 1, 8'h00); send_frame(-1, -1); idle(12);
      build(60, 8'h00, 1, 8'h01); send_frame(-1, -1); idle(12);
      build(20, 8'h40, 1, 8'h00); send_frame(-1, -1); idle(12);
      build(1519, 8'h00, 1, 8'h00); send_frame(-1, -1); idle(12);
      build(60, 8'h10, 1, 8'h00); send_frame(10, -1); idle(12);

      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h5A);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i));
      idle(12);
      build(60, 8'h80, 1, 8'h00); send_frame(-1, -1); idle(12);

      build(3, 8'h20, 0, 8'h00); send_frame(-1, -1); idle(12);
      build(0, 8'h00, 0, 8'h00); send_frame(-1, -1); idle(12);
      build(5, 8'h30, 0, 8'h00); send_frame(-1, -1); idle(12);

      build(60, 8'h00, 1, 8'h00); send_frame(-1, 30); idle(12);
      build(60, 8'h00, 1, 8'h00); send_frame(-1, -1); idle(12);
`ifdef ETH_RX_STATS_EN
      chk("rx_good_cnt", rx_good_cnt, 1);
      chk("rx_bad_cnt", rx_bad_cnt, 0);
`endif
      idle(10);
      chk("out_queue_drained", oq.size(), 0);
      chk("stat_queue_drained", sq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/eth_rx_fcs_check.md
ETH_RX_FCS_CHECK -- requirements
Module: eth_rx_fcs_check

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 1518, max legal length in bytes from DA through FCS (range 64..4000).
REQ-002 SHALL have parameter MIN_FRAME_LEN, default 64, min legal length in bytes from DA through FCS.
REQ-003 clk  in  1  byte clock, all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 rx_dv  in  1  GMII receive data valid, contiguous within a frame.
REQ-006 rx_er  in  1  GMII receive error.
REQ-007 rxd  in  8  GMII receive byte.
REQ-008 out_valid  out  1  payload byte valid (DA through last byte before FCS).
REQ-009 out_data  out  8  payload byte.
REQ-010 out_first  out  1  first payload byte (DA[0]).
REQ-011 out_last  out  1  last payload byte.
REQ-012 stat_valid  out  1  one-cycle frame status strobe.
REQ-013 stat_good  out  1  frame passed all checks; meaningful only with stat_valid.
REQ-014 stat_crc_err / stat_len_err / stat_phy_err  out  1 each  FCS mismatch / length out of range / rx_er seen.

Function
REQ-015 FSM states SHALL be IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: rx_dv=1 with rxd=0x55 -> PREAMBLE; rx_dv=1 with any other byte -> DROP.
REQ-017 PREAMBLE: 0x55 stays; 0xD5 -> DATA, CRC register preset to 0xFFFFFFFF, length counter cleared; other byte -> DROP; rx_dv=0 -> IDLE, no status.
REQ-018 DATA: each rx_dv=1 byte SHALL update IEEE 802.3 CRC-32 (poly 0x04C11DB7, byte LSB-first, no output inversion) and enter a 4-byte FCS hold line plus a 1-byte pending register.
REQ-019 DATA: rx_dv=0 -> IDLE, ending frame; frame good iff CRC register equals residue 0xC704DD7B, length within [MIN_FRAME_LEN, MAX_FRAME_LEN], no rx_er during DATA.
REQ-020 DROP: consume until rx_dv=0, then IDLE; no output, no status.
REQ-021 Length counter SHALL count DATA bytes including FCS, 12 bits, saturating at 4095.
REQ-022 Payload byte k SHALL appear on out_data exactly 6 clocks after its rxd sample; FCS bytes are never output.
REQ-023 out_last, stat_valid and status flags SHALL coincide on the clock after rx_dv is first sampled low in DATA.
REQ-024 Frames of 1-4 DATA bytes: no out_valid; stat_valid with stat_len_err=1, stat_crc_err as computed.
REQ-025 Frame of 0 DATA bytes (SFD then rx_dv=0): stat_valid with stat_len_err=1.
REQ-026 Over-length frames SHALL still be forwarded; rejection is by status only.
REQ-027 stat_good = NOT(crc_err OR len_err OR phy_err); error flags independent, several may be 1 simultaneously.
REQ-028 rx_dv=1 with rx_er=1 in IDLE/PREAMBLE SHALL move to DROP.
REQ-029 out_* and stat_* SHALL be registered; out_first, out_last, stat_valid are single-cycle pulses.

Reset
REQ-030 reset SHALL force IDLE, clear hold line, CRC register to 0xFFFFFFFF, all outputs to 0 (counters of REQ-032 to 0).
REQ-031 Reset asserted mid-frame SHALL discard the frame with no status; after release, a frame already in progress SHALL go to DROP (first byte not 0x55 or no SFD seen).

Configuration
REQ-032 With ETH_RX_STATS_EN defined: additional outputs rx_good_cnt (32) and rx_bad_cnt (32), incremented on stat_valid by good/bad, saturating at 0xFFFFFFFF.
REQ-033 Without ETH_RX_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 7x0x55, 0xD5, 60 payload bytes 0x00..0x3B, correct 4-byte FCS -> 60 out_valid bytes 0x00..0x3B, first at +6 clk, stat_good=1, all error flags 0.
REQ-035 Same frame, FCS byte 3 XOR 0x01 -> identical payload output, stat_crc_err=1, stat_good=0.
REQ-036 SFD + 20 bytes + valid FCS (24 bytes) -> stat_len_err=1, stat_crc_err=0; 1519+4 byte frame with MAX_FRAME_LEN=1518 -> stat_len_err=1.
REQ-037 rx_er=1 on payload byte 10 of a valid 64-byte frame -> stat_phy_err=1, stat_crc_err=0; preamble 0x55,0x55,0x5A -> no output, no stat_valid, next good frame accepted.
REQ-038 reset pulse at payload byte 30, rx_dv held -> no stat_valid for that frame; back-to-back good frame with 12 idle clocks gap -> stat_good=1; with ETH_RX_STATS_EN, rx_good_cnt=1.
